// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned ILEN = 32;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h1C00_0000;
   localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0340_0000;

   typedef enum logic [2:0] {
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DROP,
      S_FAULT
   } fetch_state_e;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
      logic            adef;
   } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage, instruction memory, hazard unit and decode.
interface fetch_stage_if;
   import fetch_stage_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_rvalid;
   logic [ILEN-1:0] imem_rdata;
   logic            stall;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            if_id_valid;
   logic [XLEN-1:0] if_id_pc;
   logic [ILEN-1:0] if_id_instr;
   logic            if_id_adef;

   modport master (
      output imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr, if_id_adef,
      input  imem_rvalid, imem_rdata, stall, redirect, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr, if_id_adef,
      output imem_rvalid, imem_rdata, stall, redirect, redirect_pc
   );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load has priority over flush; neither means hold.
module if_id_reg
   import fetch_stage_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   load_i,
   input  logic   flush_i,
   input  if_id_t entry_i,
   output if_id_t entry_o
);

   if_id_t entry_q, entry_d;

   // A flushed entry keeps its pc so decode still sees the last fetch address.
   always_comb begin
      entry_d = entry_q;
      if (load_i) begin
         entry_d = entry_i;
      end else if (flush_i) begin
         entry_d.valid = 1'b0;
         entry_d.instr = NOP_INSTR;
         entry_d.adef  = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         entry_q <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR, adef: 1'b0};
      end else begin
         entry_q <= entry_d;
      end
   end

   assign entry_o = entry_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: pc, request FSM and one-entry skid buffer.
// Optional macro FETCH_ALIGN_CHECK_EN enables misaligned-redirect fault reporting.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic          clk,
   input  logic          rst,
   fetch_stage_if.master bus
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [ILEN-1:0] skid_q, skid_d;

   logic            ifid_load, ifid_flush;
   if_id_t          ifid_in, ifid_q;

   logic [XLEN-1:0] tgt_pc;
   logic            tgt_fault;

`ifdef FETCH_ALIGN_CHECK_EN
   assign tgt_pc    = bus.redirect_pc;
   assign tgt_fault = |bus.redirect_pc[1:0];
`else
   assign tgt_pc    = bus.redirect_pc & ~32'h3;
   assign tgt_fault = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      skid_d     = skid_q;
      ifid_load  = 1'b0;
      ifid_flush = 1'b0;
      ifid_in    = '{valid: 1'b1, pc: pc_q, instr: NOP_INSTR, adef: 1'b0};

      if (bus.redirect) begin
         pc_d = tgt_pc;
         if (tgt_fault) begin
            ifid_load = 1'b1;
            ifid_in   = '{valid: 1'b1, pc: tgt_pc, instr: NOP_INSTR, adef: 1'b1};
            state_d   = S_FAULT;
         end else begin
            ifid_flush = 1'b1;
            // A response still in flight must be swallowed before refetching.
            case (state_q)
               S_WAIT, S_DROP: state_d = bus.imem_rvalid ? S_REQ : S_DROP;
               default:        state_d = S_REQ;
            endcase
         end
      end else begin
         case (state_q)
            S_REQ: begin
               state_d    = S_WAIT;
               ifid_flush = ~bus.stall;
            end
            S_WAIT: begin
               if (bus.imem_rvalid) begin
                  if (!bus.stall) begin
                     ifid_load = 1'b1;
                     ifid_in   = '{valid: 1'b1, pc: pc_q, instr: bus.imem_rdata, adef: 1'b0};
                     pc_d      = pc_q + 32'd4;
                     state_d   = S_REQ;
                  end else begin
                     skid_d  = bus.imem_rdata;
                     state_d = S_HOLD;
                  end
               end else begin
                  ifid_flush = ~bus.stall;
               end
            end
            S_HOLD: begin
               if (!bus.stall) begin
                  ifid_load = 1'b1;
                  ifid_in   = '{valid: 1'b1, pc: pc_q, instr: skid_q, adef: 1'b0};
                  pc_d      = pc_q + 32'd4;
                  state_d   = S_REQ;
               end
            end
            S_DROP: begin
               if (bus.imem_rvalid) state_d = S_REQ;
               ifid_flush = ~bus.stall;
            end
            default: begin
               ifid_flush = ~bus.stall;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         skid_q  <= skid_d;
      end
   end

   if_id_reg u_if_id_reg (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (ifid_load),
      .flush_i (ifid_flush),
      .entry_i (ifid_in),
      .entry_o (ifid_q)
   );

   assign bus.imem_req    = (state_q == S_REQ);
   assign bus.imem_addr   = pc_q;
   assign bus.if_id_valid = ifid_q.valid;
   assign bus.if_id_pc    = ifid_q.pc;
   assign bus.if_id_instr = ifid_q.instr;
   assign bus.if_id_adef  = ifid_q.adef;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory responses are driven by hand each step.
module tb_fetch_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int unsigned vectors = 0;
   int unsigned errs    = 0;

   always #5 clk = ~clk;

   fetch_stage_if bus ();

   fetch_stage #(.RESET_PC(32'h1C00_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;

      step();
      step();
      chk("rst_valid", {31'd0, bus.if_id_valid}, 32'd0);
      chk("rst_pc",    bus.if_id_pc,             32'h0);
      chk("rst_instr", bus.if_id_instr,          32'h0340_0000);
      chk("rst_adef",  {31'd0, bus.if_id_adef},  32'd0);
      rst = 1'b0;
      chk("first_req",  {31'd0, bus.imem_req}, 32'd1);
      chk("first_addr", bus.imem_addr,         32'h1C00_0000);

      // first fetch, zero-wait memory
      step();
      chk("wait_noreq", {31'd0, bus.imem_req}, 32'd0);
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'h0280_0421;
      step();
      bus.imem_rvalid = 1'b0;
      chk("f1_valid", {31'd0, bus.if_id_valid}, 32'd1);
      chk("f1_pc",    bus.if_id_pc,             32'h1C00_0000);
      chk("f1_instr", bus.if_id_instr,          32'h0280_0421);
      chk("f1_next",  bus.imem_addr,            32'h1C00_0004);

      // stall across the response: word parked in skid
      bus.stall = 1'b1;
      step();
      chk("st_hold_pc", bus.if_id_pc, 32'h1C00_0000);
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hAAAA_0001;
      step();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'hFFFF_FFFF;
      chk("st_hold_instr", bus.if_id_instr,          32'h0280_0421);
      chk("st_noreq1",     {31'd0, bus.imem_req},    32'd0);
      step();
      chk("st_hold_valid", {31'd0, bus.if_id_valid}, 32'd1);
      chk("st_noreq2",     {31'd0, bus.imem_req},    32'd0);
      bus.stall = 1'b0;
      step();
      chk("skid_valid", {31'd0, bus.if_id_valid}, 32'd1);
      chk("skid_pc",    bus.if_id_pc,             32'h1C00_0004);
      chk("skid_instr", bus.if_id_instr,          32'hAAAA_0001);
      chk("skid_req",   {31'd0, bus.imem_req},    32'd1);
      chk("skid_addr",  bus.imem_addr,            32'h1C00_0008);

      // no word and no stall: bubble
      step();
      chk("bub_valid", {31'd0, bus.if_id_valid}, 32'd0);
      chk("bub_instr", bus.if_id_instr,          32'h0340_0000);
      chk("bub_pc",    bus.if_id_pc,             32'h1C00_0004);

      // redirect while waiting; stale response two cycles later
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h1C00_0100;
      step();
      bus.redirect = 1'b0;
      chk("drop_noreq", {31'd0, bus.imem_req}, 32'd0);
      step();
      chk("drop_noreq2", {31'd0, bus.imem_req}, 32'd0);
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
      step();
      bus.imem_rvalid = 1'b0;
      chk("drop_valid", {31'd0, bus.if_id_valid}, 32'd0);
      chk("drop_req",   {31'd0, bus.imem_req},    32'd1);
      chk("drop_addr",  bus.imem_addr,            32'h1C00_0100);
      step();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'h1111_0000;
      step();
      bus.imem_rvalid = 1'b0;
      chk("rd_pc",    bus.if_id_pc,    32'h1C00_0100);
      chk("rd_instr", bus.if_id_instr, 32'h1111_0000);

      // redirect coincident with rvalid under stall
      bus.stall = 1'b1;
      step();
      chk("co_pre_valid", {31'd0, bus.if_id_valid}, 32'd1);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h1C00_0200;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hBAD0_BAD0;
      step();
      bus.redirect    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.stall       = 1'b0;
      chk("co_valid", {31'd0, bus.if_id_valid}, 32'd0);
      chk("co_instr", bus.if_id_instr,          32'h0340_0000);
      chk("co_pc",    bus.if_id_pc,             32'h1C00_0100);
      chk("co_req",   {31'd0, bus.imem_req},    32'd1);
      chk("co_addr",  bus.imem_addr,            32'h1C00_0200);
      step();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'h2222_0000;
      step();
      bus.imem_rvalid = 1'b0;
      chk("co_fetch_pc", bus.if_id_pc, 32'h1C00_0200);

      // redirect in S_REQ to the top of the address space; stray rvalid ignored
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFFC;
      step();
      bus.redirect = 1'b0;
      chk("wr_req",  {31'd0, bus.imem_req}, 32'd1);
      chk("wr_addr", bus.imem_addr,         32'hFFFF_FFFC);
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hBAD1_BAD1;
      step();
      chk("wr_stray", {31'd0, bus.if_id_valid}, 32'd0);
      bus.imem_rdata = 32'h3333_0000;
      step();
      bus.imem_rvalid = 1'b0;
      chk("wr_pc",    bus.if_id_pc,    32'hFFFF_FFFC);
      chk("wr_instr", bus.if_id_instr, 32'h3333_0000);
      chk("wr_next",  bus.imem_addr,   32'h0000_0000);

      // misaligned redirect coincident with a response
      step();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h1C00_0102;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'h4444_0000;
      step();
      bus.redirect    = 1'b0;
      bus.imem_rvalid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      chk("ad_adef",  {31'd0, bus.if_id_adef},  32'd1);
      chk("ad_valid", {31'd0, bus.if_id_valid}, 32'd1);
      chk("ad_pc",    bus.if_id_pc,             32'h1C00_0102);
      chk("ad_instr", bus.if_id_instr,          32'h0340_0000);
      chk("ad_noreq", {31'd0, bus.imem_req},    32'd0);
      step();
      chk("ad_noreq2", {31'd0, bus.imem_req},   32'd0);
      chk("ad_clear",  {31'd0, bus.if_id_adef}, 32'd0);
      step();
      chk("ad_noreq3", {31'd0, bus.imem_req}, 32'd0);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h1C00_0200;
      step();
      bus.redirect = 1'b0;
      chk("ad_req",  {31'd0, bus.imem_req}, 32'd1);
      chk("ad_addr", bus.imem_addr,         32'h1C00_0200);
`else
      chk("al_adef",  {31'd0, bus.if_id_adef},  32'd0);
      chk("al_valid", {31'd0, bus.if_id_valid}, 32'd0);
      chk("al_req",   {31'd0, bus.imem_req},    32'd1);
      chk("al_addr",  bus.imem_addr,            32'h1C00_0100);
      step();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'h5555_0000;
      step();
      bus.imem_rvalid = 1'b0;
      chk("al_pc",    bus.if_id_pc,    32'h1C00_0100);
      chk("al_instr", bus.if_id_instr, 32'h5555_0000);
`endif

      // reset in the middle of a transaction
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rr_valid", {31'd0, bus.if_id_valid}, 32'd0);
      chk("rr_pc",    bus.if_id_pc,             32'h0);
      chk("rr_instr", bus.if_id_instr,          32'h0340_0000);
      chk("rr_req",   {31'd0, bus.imem_req},    32'd1);
      chk("rr_addr",  bus.imem_addr,            32'h1C00_0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h1C000000, first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 imem_req  out  1  fetch request, accepted by memory in the cycle it is high.
REQ-005 imem_addr  out  32  word-aligned fetch address, valid when imem_req=1.
REQ-006 imem_rvalid  in  1  response strobe, at least one cycle after the accepted request.
REQ-007 imem_rdata  in  32  instruction word, valid with imem_rvalid.
REQ-008 stall  in  1  hazard unit holds IF/ID register.
REQ-009 redirect  in  1  branch/jump resolved taken; flush and refetch.
REQ-010 redirect_pc  in  32  new fetch target.
REQ-011 if_id_valid  out  1  IF/ID register holds a real instruction.
REQ-012 if_id_pc  out  32  PC of if_id_instr.
REQ-013 if_id_instr  out  32  instruction word consumed by the decode/control unit.
REQ-014 if_id_adef  out  1  fetch-address fault flag (see Configuration).

Function
REQ-015 FSM states: S_REQ, S_WAIT, S_HOLD, S_DROP, S_FAULT; at most one request outstanding.
REQ-016 S_REQ: imem_req=1, imem_addr=pc; next state S_WAIT; imem_req=0 in all other states.
REQ-017 S_WAIT, imem_rvalid=1, IF/ID free (stall=0): load {1, pc, imem_rdata} into IF/ID, pc<=pc+4, go S_REQ.
REQ-018 S_WAIT, imem_rvalid=1, stall=1: capture word in one-entry skid buffer, go S_HOLD; imem_rdata is never sampled outside imem_rvalid.
REQ-019 S_HOLD, stall=0: move skid entry into IF/ID, pc<=pc+4, go S_REQ.
REQ-020 stall=0 with no new word: IF/ID becomes bubble (valid=0, instr=32'h03400000 NOP, pc unchanged).
REQ-021 stall=1 with no redirect: IF/ID outputs hold their values exactly.
REQ-022 redirect takes priority over stall and rvalid: pc<=redirect_pc, IF/ID becomes bubble, skid buffer cleared, in the same edge.
REQ-023 redirect in S_WAIT with imem_rvalid=0: go S_DROP; S_DROP discards the next rvalid, then goes S_REQ.
REQ-024 redirect coincident with imem_rvalid in S_WAIT: word discarded, go S_REQ.
REQ-025 redirect in S_DROP: pc updated, remain S_DROP until the stale response arrives.
REQ-026 redirect in S_REQ/S_HOLD/S_FAULT: go S_REQ next cycle with new pc.
REQ-027 pc arithmetic is modulo 2^32; 32'hFFFFFFFC+4 wraps to 0.
REQ-028 Fetch-to-IF/ID latency: 2 cycles minimum (request cycle + response cycle), throughput one instruction per 2 cycles with zero-wait memory.

Reset
REQ-029 rst: pc=RESET_PC, state=S_REQ, skid empty, if_id_valid=0, if_id_pc=0, if_id_instr=NOP, if_id_adef=0.
REQ-030 rst mid-transaction: any outstanding response arriving after rst deasserts is ignored unless it follows the post-reset request (memory is reset in the same cycle).

Configuration
REQ-031 Macro FETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 loads IF/ID {valid=1, pc=redirect_pc, instr=NOP, adef=1}, enters S_FAULT, issues no requests until next redirect; adef clears when that IF/ID entry is overwritten or flushed.
REQ-032 Macro undefined: redirect_pc[1:0] forced to 2'b00, S_FAULT unreachable, if_id_adef tied 0.

Structure
REQ-033 Shared package holds FSM state encoding, NOP constant 32'h03400000, RESET_PC default, instruction/address widths.
REQ-034 One sub-module if_id_reg (IF/ID register with hold/flush/load) is instantiated; FSM, pc and skid buffer remain in fetch_stage.

Verification
REQ-035 Reset, zero-wait memory returning 0x02800421 at 0x1C000000 -> first imem_addr=0x1C000000, IF/ID valid with pc=0x1C000000 two cycles after rst drops.
REQ-036 stall=1 for 3 cycles while response arrives -> IF/ID unchanged, word held in skid, delivered first cycle after stall=0, no refetch.
REQ-037 redirect to 0x1C000100 while S_WAIT, response 2 cycles later -> stale word discarded, next imem_addr=0x1C000100, no IF/ID valid from stale word.
REQ-038 redirect and imem_rvalid same cycle, stall=1 -> IF/ID bubble, next request at redirect_pc.
REQ-039 pc=0xFFFFFFFC fetch -> following imem_addr=0x00000000.
REQ-040 With FETCH_ALIGN_CHECK_EN, redirect_pc=0x1C000102 -> if_id_adef=1, imem_req stays 0 until redirect to 0x1C000200; without macro, fetch at 0x1C000100.
